// File: rtl/id_ex_pipeline_register.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// Holds decode-stage control and operands for one cycle, with stall, flush and a saturating bubble counter.
module id_ex_pipeline_register #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallE,
  input  logic                  FlushE,
  input  logic                  ValidD,
  input  logic                  RegWriteD,
  input  logic                  ResultSrcD,
  input  logic                  MemWriteD,
  input  logic                  BranchD,
  input  logic                  ALUSrcD,
  input  logic [2:0]            ALUControlD,
  input  logic [XLEN-1:0]       RD1D,
  input  logic [XLEN-1:0]       RD2D,
  input  logic [XLEN-1:0]       ImmExtD,
  input  logic [XLEN-1:0]       PCD,
  input  logic [XLEN-1:0]       PCPlus4D,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  output logic                  ValidE,
  output logic                  RegWriteE,
  output logic                  ResultSrcE,
  output logic                  MemWriteE,
  output logic                  BranchE,
  output logic                  ALUSrcE,
  output logic [2:0]            ALUControlE,
  output logic [XLEN-1:0]       RD1E,
  output logic [XLEN-1:0]       RD2E,
  output logic [XLEN-1:0]       ImmExtE,
  output logic [XLEN-1:0]       PCE,
  output logic [XLEN-1:0]       PCPlus4E,
  output logic [REG_ADDR_W-1:0] Rs1E,
  output logic [REG_ADDR_W-1:0] Rs2E,
  output logic [REG_ADDR_W-1:0] RdE,
  output logic [CNT_W-1:0]      BubbleCount
);

  localparam int unsigned W_CTRL = 9;
  localparam int unsigned W_ALL  = W_CTRL + 5 * XLEN + 3 * REG_ADDR_W;

  // All stage fields travel as one word so hold and bubble zeroing treat every field identically.
  logic [W_ALL-1:0] w_d_word;
  logic [W_ALL-1:0] r_e_word;
  logic [CNT_W-1:0] r_bubble_count;

  assign w_d_word = {ValidD, RegWriteD, ResultSrcD, MemWriteD, BranchD, ALUSrcD,
                     ALUControlD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D,
                     Rs1D, Rs2D, RdD};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_e_word <= '0;
    end else if (FlushE) begin
      r_e_word <= '0;
    end else if (!StallE) begin
      r_e_word <= w_d_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_count <= '0;
    end else if (FlushE && (r_bubble_count != '1)) begin
      r_bubble_count <= r_bubble_count + 1'b1;
    end
  end

  assign {ValidE, RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE,
          ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E,
          Rs1E, Rs2E, RdE} = r_e_word;
  assign BubbleCount = r_bubble_count;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Directed self-checking bench for id_ex_pipeline_register.
// A second instance with a 4-bit counter exercises bubble-count saturation.
module tb_id_ex_pipeline_register;

  localparam int unsigned VW = 184;

  logic clk;
  logic rst, StallE, FlushE;
  logic rst4, StallE4, FlushE4;
  logic ValidD, RegWriteD, ResultSrcD, MemWriteD, BranchD, ALUSrcD;
  logic [2:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;

  logic ValidE, RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [15:0] BubbleCount;

  logic v4, rw4, rs4, mw4, br4, as4;
  logic [2:0]  alu4;
  logic [31:0] rd1_4, rd2_4, imm4, pc4, pcp4_4;
  logic [4:0]  rs1_4, rs2_4, rd4;
  logic [3:0]  BubbleCount4;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  logic [VW-1:0] e_word, v_a, v_b, v_c;

  id_ex_pipeline_register dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
    .MemWriteD(MemWriteD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
    .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .MemWriteE(MemWriteE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .BubbleCount(BubbleCount)
  );

  id_ex_pipeline_register #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst4), .StallE(StallE4), .FlushE(FlushE4),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD),
    .MemWriteD(MemWriteD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
    .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ValidE(v4), .RegWriteE(rw4), .ResultSrcE(rs4),
    .MemWriteE(mw4), .BranchE(br4), .ALUSrcE(as4),
    .ALUControlE(alu4), .RD1E(rd1_4), .RD2E(rd2_4), .ImmExtE(imm4),
    .PCE(pc4), .PCPlus4E(pcp4_4), .Rs1E(rs1_4), .Rs2E(rs2_4), .RdE(rd4),
    .BubbleCount(BubbleCount4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign e_word = {ValidE, RegWriteE, ResultSrcE, MemWriteE, BranchE, ALUSrcE,
                   ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, Rs1E, Rs2E, RdE};

  task automatic drive(input logic [VW-1:0] v);
    {ValidD, RegWriteD, ResultSrcD, MemWriteD, BranchD, ALUSrcD,
     ALUControlD, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD} = v;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    v_a = {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h0000_0005, 32'hDEAD_BEEF,
           32'hFFFF_FFF0, 32'h0000_0100, 32'h0000_0104, 5'd3, 5'd4, 5'd7};
    v_b = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b110, 32'h1234_5678, 32'h8765_4321,
           32'h0000_0800, 32'h0000_2000, 32'h0000_2004, 5'd31, 5'd1, 5'd30};
    v_c = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b101, 32'hA5A5_A5A5, 32'h5A5A_5A5A,
           32'h0000_0FFF, 32'h0000_0040, 32'h0000_0044, 5'd9, 5'd10, 5'd11};

    rst = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    rst4 = 1'b1; StallE4 = 1'b0; FlushE4 = 1'b0;
    drive(v_b);
    step(); step();
    chk("reset_fields", e_word, '0);
    chk("reset_count", {168'd0, BubbleCount}, '0);
    chk("reset_count4", {180'd0, BubbleCount4}, '0);

    rst = 1'b0; rst4 = 1'b0;
    drive(v_a);
    step();
    chk("load_regwrite", {183'd0, RegWriteE}, 184'd1);
    chk("load_aluctrl", {181'd0, ALUControlE}, 184'd2);
    chk("load_rd1", {152'd0, RD1E}, 184'd5);
    chk("load_rd", {179'd0, RdE}, 184'd7);
    chk("load_valid", {183'd0, ValidE}, 184'd1);
    chk("load_all", e_word, v_a);

    StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      step();
      chk("stall_hold", e_word, v_a);
    end
    chk("stall_count", {168'd0, BubbleCount}, '0);

    FlushE = 1'b1;
    drive(v_c);
    step();
    chk("flush_stall_fields", e_word, '0);
    chk("flush_stall_rd", {179'd0, RdE}, '0);
    chk("flush_stall_count", {168'd0, BubbleCount}, 184'd1);

    FlushE = 1'b0; StallE = 1'b0;
    drive(v_b);
    step();
    chk("load_invalid", e_word, v_b);
    chk("load_count_kept", {168'd0, BubbleCount}, 184'd1);

    FlushE = 1'b1;
    step();
    chk("flush_fields", e_word, '0);
    chk("flush_count2", {168'd0, BubbleCount}, 184'd2);
    for (int i = 0; i < 7; i++) step();
    chk("flush_count9", {168'd0, BubbleCount}, 184'd9);

    FlushE = 1'b0;
    drive(v_c);
    step();
    chk("reload", e_word, v_c);
    StallE = 1'b1; rst = 1'b1;
    drive(v_a);
    step();
    chk("rst_in_stall_fields", e_word, '0);
    chk("rst_in_stall_count", {168'd0, BubbleCount}, '0);
    rst = 1'b0; StallE = 1'b0;
    step();
    chk("after_rst_load", e_word, v_a);

    FlushE4 = 1'b1; StallE4 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) chk("sat_count14", {180'd0, BubbleCount4}, 184'hE);
      if (i == 15) chk("sat_count15", {180'd0, BubbleCount4}, 184'hF);
    end
    chk("sat_count20", {180'd0, BubbleCount4}, 184'hF);
    chk("sat_fields", {179'd0, rd4}, '0);
    FlushE4 = 1'b0; StallE4 = 1'b0;
    step();
    chk("sat_hold", {180'd0, BubbleCount4}, 184'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
